// File: rtl/fp_regfile_sb.sv
// ----------------------------------------------------------------------------
// fp_regfile_sb
// Floating-point register file with a busy-bit scoreboard for the pipelined
// MIPS core. It supports single (fmt 5'h10) and double (fmt 5'h11, even/odd
// register pair) accesses, with a separate format on each access port.
// Reads are registered and bypass a same-cycle write. The scoreboard tracks
// destinations that have issued but not yet written back.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   rd_en/rd_fmt        read capture strobe and format (shared by both ports)
//   rd_addr1/rd_addr2   source registers
//   rd_data1/rd_data2   registered read data (2*WORD_W; upper half 0 if single)
//   rd_busy             registered: a source was busy when the read was captured
//   wr_en/wr_fmt/       write-back strobe, format, destination and data
//   wr_addr/wr_data       (the upper half of a double goes to wr_addr+1)
//   iss_en/iss_fmt/     issue strobe: marks the destination busy
//   iss_addr
//   hazard              combinational RAW hazard for the current read inputs
//   fmt_err             one-cycle registered pulse for any illegal access
// ----------------------------------------------------------------------------
module fp_regfile_sb #(
   parameter int NUM_REGS    = 32,
   parameter int WORD_W      = 32,
   parameter int ADDR_W      = $clog2(NUM_REGS),
   parameter int RESET_INDEX = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rd_en,
   input  logic [4:0]          rd_fmt,
   input  logic [ADDR_W-1:0]   rd_addr1,
   input  logic [ADDR_W-1:0]   rd_addr2,
   output logic [2*WORD_W-1:0] rd_data1,
   output logic [2*WORD_W-1:0] rd_data2,
   output logic                rd_busy,
   input  logic                wr_en,
   input  logic [4:0]          wr_fmt,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [2*WORD_W-1:0] wr_data,
   input  logic                iss_en,
   input  logic [4:0]          iss_fmt,
   input  logic [ADDR_W-1:0]   iss_addr,
   output logic                hazard,
   output logic                fmt_err
);

   localparam logic [4:0] FMT_S = 5'h10;
   localparam logic [4:0] FMT_D = 5'h11;

   // A double must start on an even register; any other format is illegal.
   function automatic logic fmt_legal(input logic [4:0] fmt, input logic [ADDR_W-1:0] addr);
      logic ok;
      case (fmt)
         FMT_S:   ok = 1'b1;
         FMT_D:   ok = ~addr[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Odd partner of an even register. It never wraps past NUM_REGS-1.
   function automatic logic [ADDR_W-1:0] pair_hi(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:1], 1'b1};
   endfunction

   // Value a read of register idx sees, including any same-cycle write.
   function automatic logic [WORD_W-1:0] fwd_word(
      input logic [ADDR_W-1:0]   idx,
      input logic [WORD_W-1:0]   cur,
      input logic                upd,
      input logic                dbl,
      input logic [ADDR_W-1:0]   waddr,
      input logic [2*WORD_W-1:0] wdata
   );
      logic [WORD_W-1:0] val;
      if (upd && (idx == waddr)) begin
         val = wdata[WORD_W-1:0];
      end else if (upd && dbl && (idx == pair_hi(waddr))) begin
         val = wdata[2*WORD_W-1:WORD_W];
      end else begin
         val = cur;
      end
      return val;
   endfunction

   logic [WORD_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;

   logic                wr_legal, wr_dbl, wr_upd;
   logic                iss_legal, iss_dbl, iss_set;
   logic                rd1_legal, rd2_legal, rd_dbl;
   logic [NUM_REGS-1:0] wr_mask, iss_mask;
   logic [WORD_W-1:0]   rd1_lo, rd1_hi, rd2_lo, rd2_hi;
   logic [2*WORD_W-1:0] rd1_val, rd2_val;
   logic                src1_busy, src2_busy;
   logic                err_now;

   // Decode legality and the effective write/issue actions.
   always_comb begin
      wr_legal  = fmt_legal(wr_fmt, wr_addr);
      wr_dbl    = (wr_fmt == FMT_D);
      // A write to register 0 is dropped but still counts as a write-back.
      wr_upd    = wr_en && wr_legal && (wr_addr != {ADDR_W{1'b0}});
      iss_legal = fmt_legal(iss_fmt, iss_addr);
      iss_dbl   = (iss_fmt == FMT_D);
      iss_set   = iss_en && iss_legal && (iss_addr != {ADDR_W{1'b0}});
      rd1_legal = fmt_legal(rd_fmt, rd_addr1);
      rd2_legal = fmt_legal(rd_fmt, rd_addr2);
      rd_dbl    = (rd_fmt == FMT_D);
      err_now   = (wr_en && !wr_legal) || (iss_en && !iss_legal) ||
                  (rd_en && !(rd1_legal && rd2_legal));
   end

   // Scoreboard clear mask (legal write-back) and set mask (legal issue).
   always_comb begin
      wr_mask  = {NUM_REGS{1'b0}};
      iss_mask = {NUM_REGS{1'b0}};
      if (wr_en && wr_legal) begin
         wr_mask[wr_addr] = 1'b1;
         if (wr_dbl) begin
            wr_mask[pair_hi(wr_addr)] = 1'b1;
         end else begin
            wr_mask[wr_addr] = 1'b1;
         end
      end else begin
         wr_mask = {NUM_REGS{1'b0}};
      end
      if (iss_set) begin
         iss_mask[iss_addr] = 1'b1;
         if (iss_dbl) begin
            iss_mask[pair_hi(iss_addr)] = 1'b1;
         end else begin
            iss_mask[iss_addr] = 1'b1;
         end
      end else begin
         iss_mask = {NUM_REGS{1'b0}};
      end
   end

   // Read words with bypass, assembled per port; an illegal port reads 0.
   always_comb begin
      rd1_lo = fwd_word(rd_addr1,          regs[rd_addr1],          wr_upd, wr_dbl, wr_addr, wr_data);
      rd1_hi = fwd_word(pair_hi(rd_addr1), regs[pair_hi(rd_addr1)], wr_upd, wr_dbl, wr_addr, wr_data);
      rd2_lo = fwd_word(rd_addr2,          regs[rd_addr2],          wr_upd, wr_dbl, wr_addr, wr_data);
      rd2_hi = fwd_word(pair_hi(rd_addr2), regs[pair_hi(rd_addr2)], wr_upd, wr_dbl, wr_addr, wr_data);
      if (!rd1_legal) begin
         rd1_val = {2*WORD_W{1'b0}};
      end else if (rd_dbl) begin
         rd1_val = {rd1_hi, rd1_lo};
      end else begin
         rd1_val = {{WORD_W{1'b0}}, rd1_lo};
      end
      if (!rd2_legal) begin
         rd2_val = {2*WORD_W{1'b0}};
      end else if (rd_dbl) begin
         rd2_val = {rd2_hi, rd2_lo};
      end else begin
         rd2_val = {{WORD_W{1'b0}}, rd2_lo};
      end
   end

   // Source busy lookup from the current scoreboard. A same-cycle write-back
   // does not mask it.
   always_comb begin
      src1_busy = rd1_legal && (busy[rd_addr1] || (rd_dbl && busy[pair_hi(rd_addr1)]));
      src2_busy = rd2_legal && (busy[rd_addr2] || (rd_dbl && busy[pair_hi(rd_addr2)]));
      hazard    = rd_en && (src1_busy || src2_busy);
   end

   // Register array: reset image, then legal non-zero writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (RESET_INDEX != 0) ? WORD_W'(i) : {WORD_W{1'b0}};
         end
      end else if (wr_upd) begin
         regs[wr_addr] <= wr_data[WORD_W-1:0];
         if (wr_dbl) begin
            regs[pair_hi(wr_addr)] <= wr_data[2*WORD_W-1:WORD_W];
         end
      end
   end

   // Scoreboard: clear on write-back first, so that a same-cycle issue wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= {NUM_REGS{1'b0}};
      end else begin
         busy <= (busy & ~wr_mask) | iss_mask;
      end
   end

   // Registered read outputs, which hold while rd_en is low, and the error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data1 <= {2*WORD_W{1'b0}};
         rd_data2 <= {2*WORD_W{1'b0}};
         rd_busy  <= 1'b0;
         fmt_err  <= 1'b0;
      end else begin
         fmt_err <= err_now;
         if (rd_en) begin
            rd_data1 <= rd1_val;
            rd_data2 <= rd2_val;
            rd_busy  <= src1_busy || src2_busy;
         end else begin
            rd_data1 <= rd_data1;
            rd_data2 <= rd_data2;
            rd_busy  <= rd_busy;
         end
      end
   end

endmodule

// File: tb/tb_fp_regfile_sb.sv
// ----------------------------------------------------------------------------
// tb_fp_regfile_sb
// Directed bench for fp_regfile_sb with the default parameters (32 x 32-bit
// registers, RESET_INDEX=1). A behavioural model of the register contents and
// busy set is advanced once per clock. A compare process checks every DUT
// output against the model on each falling edge. Hand-computed literals pin
// the important results.
// ----------------------------------------------------------------------------
module tb_fp_regfile_sb;

   localparam int NR = 32;
   localparam logic [4:0] S = 5'h10;
   localparam logic [4:0] D = 5'h11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd_en = 1'b0;
   logic [4:0]  rd_fmt = S;
   logic [4:0]  rd_addr1 = 5'd0, rd_addr2 = 5'd0;
   logic [63:0] rd_data1, rd_data2;
   logic        rd_busy;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_fmt = S;
   logic [4:0]  wr_addr = 5'd0;
   logic [63:0] wr_data = 64'h0;
   logic        iss_en = 1'b0;
   logic [4:0]  iss_fmt = S;
   logic [4:0]  iss_addr = 5'd0;
   logic        hazard;
   logic        fmt_err;

   fp_regfile_sb dut (
      .clk(clk), .rst(rst),
      .rd_en(rd_en), .rd_fmt(rd_fmt), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_fmt(wr_fmt), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_en(iss_en), .iss_fmt(iss_fmt), .iss_addr(iss_addr),
      .hazard(hazard), .fmt_err(fmt_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic chk_on = 1'b0;

   // Model state
   logic [31:0] m_regs [NR];
   logic [31:0] m_busy;
   logic [63:0] exp_rd1, exp_rd2;
   logic        exp_rbusy, exp_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic legal(input logic [4:0] f, input int a);
      return (f == S) || ((f == D) && (a % 2 == 0));
   endfunction

   function automatic logic src_busy(input logic [31:0] b, input logic [4:0] f, input int a);
      if (!legal(f, a)) return 1'b0;
      if (f == D) return b[a] | b[a+1];
      return b[a];
   endfunction

   function automatic logic model_hazard();
      return rd_en && (src_busy(m_busy, rd_fmt, int'(rd_addr1)) ||
                       src_busy(m_busy, rd_fmt, int'(rd_addr2)));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NR; i++) m_regs[i] = i;
      m_busy    = 32'h0;
      exp_rd1   = 64'h0;
      exp_rd2   = 64'h0;
      exp_rbusy = 1'b0;
      exp_err   = 1'b0;
   endtask

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (chk_on) begin
         check("rd_data1", rd_data1, exp_rd1);
         check("rd_data2", rd_data2, exp_rd2);
         check("rd_busy",  {63'h0, rd_busy}, {63'h0, exp_rbusy});
         check("fmt_err",  {63'h0, fmt_err}, {63'h0, exp_err});
         check("hazard",   {63'h0, hazard},  {63'h0, model_hazard()});
      end
   end

   task automatic drive(input logic re, input logic [4:0] rf, input int a1, input int a2,
                        input logic we, input logic [4:0] wf, input int wa, input logic [63:0] wd,
                        input logic ie, input logic [4:0] ifm, input int ia);
      rd_en = re; rd_fmt = rf; rd_addr1 = a1[4:0]; rd_addr2 = a2[4:0];
      wr_en = we; wr_fmt = wf; wr_addr = wa[4:0]; wr_data = wd;
      iss_en = ie; iss_fmt = ifm; iss_addr = ia[4:0];
   endtask

   task automatic idle();
      drive(1'b0, S, 0, 0, 1'b0, S, 0, 64'h0, 1'b0, S, 0);
   endtask

   // Advance the model across one rising edge, working from the pre-edge
   // inputs and state. The call returns 1 time unit after the edge.
   task automatic step();
      logic [31:0] n_regs [NR];
      logic [31:0] n_busy;
      logic [63:0] n_rd1, n_rd2;
      logic        n_rbusy, n_err;
      int          a, w;
      for (int i = 0; i < NR; i++) n_regs[i] = m_regs[i];
      n_busy = m_busy; n_rd1 = exp_rd1; n_rd2 = exp_rd2; n_rbusy = exp_rbusy; n_err = 1'b0;
      if (!rst) begin
         w = int'(wr_addr);
         if (wr_en && legal(wr_fmt, w)) begin
            for (int k = 0; k < ((wr_fmt == D) ? 2 : 1); k++) begin
               n_busy[w+k] = 1'b0;
               if (w != 0) n_regs[w+k] = (k == 0) ? wr_data[31:0] : wr_data[63:32];
            end
         end
         a = int'(iss_addr);
         if (iss_en && legal(iss_fmt, a) && a != 0) begin
            n_busy[a] = 1'b1;
            if (iss_fmt == D) n_busy[a+1] = 1'b1;
         end
         if (rd_en) begin
            a = int'(rd_addr1);
            n_rd1 = !legal(rd_fmt, a) ? 64'h0 :
                    (rd_fmt == D) ? {n_regs[a+1], n_regs[a]} : {32'h0, n_regs[a]};
            a = int'(rd_addr2);
            n_rd2 = !legal(rd_fmt, a) ? 64'h0 :
                    (rd_fmt == D) ? {n_regs[a+1], n_regs[a]} : {32'h0, n_regs[a]};
            n_rbusy = model_hazard();
         end
         n_err = (wr_en && !legal(wr_fmt, int'(wr_addr))) ||
                 (iss_en && !legal(iss_fmt, int'(iss_addr))) ||
                 (rd_en && !(legal(rd_fmt, int'(rd_addr1)) && legal(rd_fmt, int'(rd_addr2))));
      end
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < NR; i++) m_regs[i] = n_regs[i];
         m_busy = n_busy; exp_rd1 = n_rd1; exp_rd2 = n_rd2; exp_rbusy = n_rbusy; exp_err = n_err;
      end
      #1;
   endtask

   initial begin
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      chk_on = 1'b1;

      // Reset image
      drive(1'b1, S, 5, 7, 1'b0, S, 0, 64'h0, 1'b0, S, 0); step();
      check("t1_rd1", rd_data1, 64'h5);
      check("t1_rd2", rd_data2, 64'h7);
      check("t1_busy", {63'h0, rd_busy}, 64'h0);
      check("t1_err", {63'h0, fmt_err}, 64'h0);

      // Double write, then double and single reads
      drive(1'b0, S, 0, 0, 1'b1, D, 4, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, S, 0); step();
      drive(1'b1, D, 4, 30, 1'b0, S, 0, 64'h0, 1'b0, S, 0); step();
      check("t2_rd_d4", rd_data1, 64'hAAAA_BBBB_CCCC_DDDD);
      check("t2_rd_d30", rd_data2, 64'h0000_001F_0000_001E);
      drive(1'b1, S, 5, 4, 1'b0, S, 0, 64'h0, 1'b0, S, 0); step();
      check("t2_rd_s5", rd_data1, 64'h0000_0000_AAAA_BBBB);
      check("t2_rd_s4", rd_data2, 64'h0000_0000_CCCC_DDDD);

      // Bypass and register 0
      drive(1'b1, S, 6, 0, 1'b1, S, 6, 64'h1234, 1'b0, S, 0); step();
      check("t3_bypass", rd_data1, 64'h1234);
      drive(1'b1, S, 0, 6, 1'b1, S, 0, 64'hFFFF, 1'b0, S, 0); step();
      check("t3_reg0_byp", rd_data1, 64'h0);
      check("t3_reg6", rd_data2, 64'h1234);
      drive(1'b1, S, 0, 0, 1'b0, S, 0, 64'h0, 1'b0, S, 0); step();
      check("t3_reg0", rd_data1, 64'h0);
      drive(1'b1, D, 12, 12, 1'b1, S, 13, 64'h77, 1'b0, S, 0); step();
      check("t3_odd_byp", rd_data1, 64'h0000_0077_0000_000C);
      drive(1'b0, S, 0, 0, 1'b1, D, 30, 64'h1111_2222_3333_4444, 1'b0, S, 0); step();
      drive(1'b1, D, 30, 30, 1'b0, S, 0, 64'h0, 1'b0, S, 0); step();
      check("t3_last_pair", rd_data1, 64'h1111_2222_3333_4444);

      // Illegal accesses
      drive(1'b1, D, 3, 3, 1'b0, S, 0, 64'h0, 1'b0, S, 0); step();
      check("t4_odd_rd", rd_data1, 64'h0);
      check("t4_err_rd", {63'h0, fmt_err}, 64'h1);
      idle(); step();
      check("t4_err_drop", {63'h0, fmt_err}, 64'h0);
      drive(1'b0, S, 0, 0, 1'b1, 5'h14, 6, 64'h9999, 1'b0, S, 0); step();
      check("t4_err_wr", {63'h0, fmt_err}, 64'h1);
      drive(1'b1, S, 6, 6, 1'b0, S, 0, 64'h0, 1'b0, S, 0); step();
      check("t4_no_upd", rd_data1, 64'h1234);

      // Scoreboard
      drive(1'b0, S, 0, 0, 1'b0, S, 0, 64'h0, 1'b1, D, 8); step();
      drive(1'b1, S, 9, 9, 1'b0, S, 0, 64'h0, 1'b0, S, 0); #1;
      check("t5_hazard", {63'h0, hazard}, 64'h1);
      step();
      check("t5_rd_busy", {63'h0, rd_busy}, 64'h1);
      drive(1'b1, S, 9, 9, 1'b1, D, 8, 64'h0000_00AB_0000_00CD, 1'b0, S, 0); #1;
      check("t5_wb_nomask", {63'h0, hazard}, 64'h1);
      step();
      drive(1'b1, S, 9, 9, 1'b0, S, 0, 64'h0, 1'b0, S, 0); #1;
      check("t5_cleared", {63'h0, hazard}, 64'h0);
      step();
      check("t5_rd9", rd_data1, 64'hAB);
      drive(1'b0, S, 0, 0, 1'b1, S, 10, 64'h55, 1'b1, S, 10); step();
      drive(1'b1, S, 10, 10, 1'b0, S, 0, 64'h0, 1'b0, S, 0); #1;
      check("t5_set_wins", {63'h0, hazard}, 64'h1);
      step();
      check("t5_rd10", rd_data1, 64'h55);

      // Asynchronous reset between issue and write-back
      drive(1'b0, S, 0, 0, 1'b0, S, 0, 64'h0, 1'b1, D, 8); step();
      drive(1'b1, S, 9, 9, 1'b0, S, 0, 64'h0, 1'b0, S, 0); #1;
      check("t6_pre_hazard", {63'h0, hazard}, 64'h1);
      rst = 1'b1;
      model_reset();
      #1;
      check("t6_hazard", {63'h0, hazard}, 64'h0);
      check("t6_rd1", rd_data1, 64'h0);
      step();
      rst = 1'b0;
      drive(1'b1, D, 4, 8, 1'b0, S, 0, 64'h0, 1'b0, S, 0); step();
      check("t6_restored4", rd_data1, 64'h0000_0005_0000_0004);
      check("t6_restored8", rd_data2, 64'h0000_0009_0000_0008);
      idle(); step();

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
